// File: rtl/key_conditioner_if.sv
// Key bus between the raw DE-series pushbuttons and the counter logic.
// The bench or board drives KEY. The conditioner returns the clean level and the press/release strobes.
interface key_conditioner_if #(
  parameter int unsigned NKEYS = 4
);
  logic [NKEYS-1:0] KEY;
  logic [NKEYS-1:0] key_level;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;

  modport master (output KEY, input key_level, key_press, key_release);
  modport slave  (input KEY, output key_level, key_press, key_release);
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debouncer and press/release strobe generator for active-low KEY inputs.
// Optional auto-repeat of key_press while a key is held: define KEYCOND_REPEAT_EN.
module key_conditioner #(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic          CLOCK_50,
  input logic          Resetn,
  key_conditioner_if.slave keys
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {UP, CHK_DOWN, DOWN, CHK_UP} state_t;

  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] release_q;
  state_t           state [NKEYS];
  logic [CNT_W-1:0] cnt   [NKEYS];

`ifdef KEYCOND_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt   [NKEYS];
  logic [NKEYS-1:0] rep_armed;
  logic [NKEYS-1:0] rep_hit_c;
  logic [NKEYS-1:0] rep_active_c;

  // The first repeat waits REPEAT_DELAY. Later repeats wait REPEAT_PERIOD.
  // The edge that returns a channel to UP never carries a repeat.
  always_comb begin
    rep_hit_c    = '0;
    rep_active_c = '0;
    for (int i = 0; i < NKEYS; i++) begin
      rep_hit_c[i] = rep_armed[i] ? (rep_cnt[i] == REP_W'(REPEAT_PERIOD - 1))
                                  : (rep_cnt[i] == REP_W'(REPEAT_DELAY - 1));
      rep_active_c[i] = (state[i] == DOWN) ||
                        ((state[i] == CHK_UP) && !(s2[i] && (cnt[i] == CNT_LAST)));
    end
  end
`endif

  // Synchronizer and per-channel debounce FSM; s2 low means pressed.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      s1        <= '1;
      s2        <= '1;
      level     <= '0;
      press     <= '0;
      release_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        state[i] <= UP;
        cnt[i]   <= '0;
`ifdef KEYCOND_REPEAT_EN
        rep_cnt[i]   <= '0;
        rep_armed[i] <= 1'b0;
`endif
      end
    end else begin
      s1        <= keys.KEY;
      s2        <= s1;
      press     <= '0;
      release_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        case (state[i])
          UP: begin
            if (!s2[i]) begin
              state[i] <= CHK_DOWN;
              cnt[i]   <= CNT_W'(1);
            end
          end
          CHK_DOWN: begin
            if (s2[i]) begin
              state[i] <= UP;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i] <= DOWN;
              cnt[i]   <= '0;
              level[i] <= 1'b1;
              press[i] <= 1'b1;
`ifdef KEYCOND_REPEAT_EN
              rep_cnt[i]   <= '0;
              rep_armed[i] <= 1'b0;
`endif
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          DOWN: begin
            if (s2[i]) begin
              state[i] <= CHK_UP;
              cnt[i]   <= CNT_W'(1);
            end
          end
          CHK_UP: begin
            if (!s2[i]) begin
              state[i] <= DOWN;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]     <= UP;
              cnt[i]       <= '0;
              level[i]     <= 1'b0;
              release_q[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= UP;
            cnt[i]   <= '0;
          end
        endcase
`ifdef KEYCOND_REPEAT_EN
        if (rep_active_c[i]) begin
          if (rep_hit_c[i]) begin
            press[i]     <= 1'b1;
            rep_cnt[i]   <= '0;
            rep_armed[i] <= 1'b1;
          end else begin
            rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
          end
        end
`endif
      end
    end
  end

  assign keys.key_level   = level;
  assign keys.key_press   = press;
  assign keys.key_release = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Expected pulse positions are counted from the edge where the first synchronizer flop captures the new KEY level.
module tb_key_conditioner;

`ifdef KEYCOND_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  key_conditioner_if #(.NKEYS(4)) bus ();

  key_conditioner #(
    .NKEYS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .CLOCK_50(clk),
    .Resetn(rst_n),
    .keys(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel);
    check({tag, " level"},   bus.key_level,   lvl);
    check({tag, " press"},   bus.key_press,   prs);
    check({tag, " release"}, bus.key_release, rel);
  endtask

  task automatic settle();
    bus.KEY = 4'hF;
    repeat (12) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] el, ep, er;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.KEY = 4'hF;

    // Reset state, then reset asserted in the middle of a debounce
    repeat (3) tick();
    check_all("reset", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_all("idle", 4'h0, 4'h0, 4'h0);
    bus.KEY = 4'hE;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 check_all("mid_debounce_reset", 4'h0, 4'h0, 4'h0);
    bus.KEY = 4'hF;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("post_reset c%0d", i), 4'h0, 4'h0, 4'h0);
    end

    // Clean press on KEY[1]: press at 5, release at 25
    for (int i = 0; i < 30; i++) begin
      bus.KEY = (i < 20) ? 4'hD : 4'hF;
      tick();
      el = {2'b00, (i >= 5 && i < 25), 1'b0};
      ep = {2'b00, (i == 5), 1'b0};
      er = {2'b00, (i == 25), 1'b0};
      check_all($sformatf("clean c%0d", i), el, ep, er);
    end
    settle();

    // Bounce on KEY[2], steady low from edge 8, so the press comes at 13
    for (int i = 0; i < 21; i++) begin
      bus.KEY = (i == 3 || i == 7) ? 4'hF : 4'hB;
      tick();
      el = {1'b0, (i >= 13), 2'b00};
      ep = {1'b0, (i == 13), 2'b00};
      check_all($sformatf("bounce c%0d", i), el, ep, 4'h0);
    end
    settle();

    // KEY[0] and KEY[3] fall together; KEY[3] is released 2 cycles earlier
    for (int i = 0; i < 22; i++) begin
      bus.KEY = {(i >= 10), 2'b11, (i >= 12)};
      tick();
      el = {(i >= 5 && i < 15), 2'b00, (i >= 5 && i < 17)};
      ep = {(i == 5), 2'b00, (i == 5)};
      er = {(i == 15), 2'b00, (i == 17)};
      check_all($sformatf("simul c%0d", i), el, ep, er);
    end
    settle();

    // Async reset drops a held level at once, then the key still held is a fresh press
    bus.KEY = 4'hD;
    repeat (8) tick();
    check("held_level", bus.key_level, 4'h2);
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 4'h0, 4'h0, 4'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      el = {2'b00, (i >= 5), 1'b0};
      ep = {2'b00, (i == 5 || (REP_EN && i == 25)), 1'b0};
      check_all($sformatf("held_reset c%0d", i), el, ep, 4'h0);
    end
    settle();

    // Long hold on KEY[0]: auto-repeat pulses only when the feature is built in
    for (int i = 0; i < 61; i++) begin
      bus.KEY = (i < 50) ? 4'hE : 4'hF;
      tick();
      el = {3'b000, (i >= 5 && i < 55)};
      ep = {3'b000, (i == 5 || (REP_EN && (i == 25 || i == 33 || i == 41 || i == 49)))};
      er = {3'b000, (i == 55)};
      check_all($sformatf("repeat c%0d", i), el, ep, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
